block_write_arbiter: RTL and testbench
======================================

Name: block_write_arbiter

Overview:
- Round-robin arbiter that shares the single block-store writer port between NSRC serial block sources, e.g. host links or a test-pattern generator.
- A grant is locked for a whole block of NWORDS words, so words from different sources never interleave in the storage shift register.
- Sits directly upstream of block_storage; its output drives the writeValid / writeReady / blockData side of the store.

Parameters:
- LOGNSRC, 2, log2 of the number of sources; NSRC = 2**LOGNSRC.
- DWIDTH, 32, width of one block word.
- NWORDS, 11, words per block (11 x 32 = 352 bits of initial state).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- src_valid  in  NSRC  per-source word valid.
- src_data  in  NSRC*DWIDTH  per-source word; source i occupies bits [i*DWIDTH +: DWIDTH].
- src_ready  out  NSRC  per-source word accepted; one-hot or zero.
- wr_valid  out  1  word valid toward the block store.
- wr_data  out  DWIDTH  word toward the block store.
- wr_ready  in  1  block store can accept a word.
- busy  out  1  a grant is locked.
- grant_id  out  LOGNSRC  index of the locked source; holds its last value when not busy.
- block_done  out  1  one-cycle pulse after the final word of a block transfers.

Behaviour:
- Reset, sampled on the clk edge while rst_n=0:
  - state=IDLE, rr_ptr=0, word_cnt=0, grant_id=0, block_done=0.
  - Combinational outputs src_ready=0 and wr_valid=0 follow from IDLE.
  - Reset has priority over every other event.
- Terminology: a beat is any cycle with wr_valid & wr_ready.
- IDLE state:
  - src_ready=0, wr_valid=0, busy=0.
  - If any src_valid bit is set, select the first set index searching upward from rr_ptr, wrapping modulo NSRC.
  - Register that index into grant_id, clear word_cnt, go to LOCKED.
  - This costs one bubble cycle per block; the first word can transfer in the cycle after the request is seen.
- LOCKED state:
  - busy=1.
  - wr_valid = src_valid[grant_id]; wr_data = src_data[grant_id].
  - src_ready[grant_id] = wr_ready; all other src_ready bits are 0.
  - A beat with word_cnt < NWORDS-1: word_cnt increments.
  - A beat with word_cnt == NWORDS-1:
    - next cycle: state=IDLE, block_done=1, rr_ptr = grant_id+1 mod NSRC (wraps naturally in LOGNSRC bits), word_cnt=0.
- block_done:
  - registered, high for exactly one cycle per completed block;
  - it coincides with the IDLE bubble.
- Stall rules:
  - If the granted source drops src_valid mid-block, the grant is held indefinitely and no other source is served. There is no timeout; sources must deliver whole blocks.
  - wr_ready low holds word_cnt and holds src_ready low for the granted source; data is not consumed.
- Non-granted sources may assert valid at any time. Their requests are only examined in IDLE, and they are never acknowledged while another grant is locked.
- Fairness: after source k completes a block, every other requesting source is served once before k again. Worst-case wait is (NSRC-1) blocks.
- Mid-block reset: the partial block is abandoned. The block store must be reset in the same cycle; the arbiter guarantees no further beats until a fresh grant.
- Combinational paths:
  - wr_data / wr_valid are a pure mux of src inputs selected by registered state; there is no added latency.
  - src_ready depends combinationally on wr_ready.
- word_cnt width is clog2(NWORDS); it never exceeds NWORDS-1.

Test Plan:
- Single source: after reset, src_valid[1]=1 continuously, wr_ready=1.
  - Cycle 0 IDLE.
  - Cycles 1-11: 11 beats, src_ready=4'b0010.
  - Cycle 12: block_done=1, busy=0.
  - grant_id=1 throughout.
- Simultaneous requests: sources 0 and 2 both valid from reset release.
  - Source 0 gets a full 11-word block first, then source 2.
  - rr_ptr=3 after the second block; wr_data never interleaves.
- Rotation: all four sources always valid.
  - Grant order is 0,1,2,3,0 over five blocks.
  - Exactly 5 block_done pulses, 12 cycles apart with wr_ready=1.
- Backpressure: toggle wr_ready 1,0,1,0 during a block from source 3.
  - Exactly 11 beats occur.
  - src_ready[3] mirrors wr_ready.
  - block_done arrives after 22 LOCKED cycles.
- Source stall: source 0 drops valid after word 5 for 20 cycles while source 1 is valid.
  - busy stays 1, grant_id=0, zero beats from source 1.
  - Transfer resumes at word 6; source 1 is served next.
- Mid-block reset: rst_n=0 for one cycle after word 4 of source 2.
  - Next cycle busy=0, src_ready=0, wr_valid=0, grant_id=0.
  - The following grant starts at word_cnt=0 and searches from rr_ptr=0.

Source files
------------

// File: rtl/block_write_arbiter.sv
// Round-robin arbiter sharing the block-store writer port between NSRC serial sources.
// A grant stays locked for a full block of NWORDS words so blocks never interleave.
module block_write_arbiter #(
  parameter int LOGNSRC = 2,
  parameter int DWIDTH  = 32,
  parameter int NWORDS  = 11,
  localparam int NSRC   = 2 ** LOGNSRC,
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC*DWIDTH-1:0] src_data,
  output logic [NSRC-1:0]        src_ready,
  output logic                   wr_valid,
  output logic [DWIDTH-1:0]      wr_data,
  input  logic                   wr_ready,
  output logic                   busy,
  output logic [LOGNSRC-1:0]     grant_id,
  output logic                   block_done
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state_r;
  logic [LOGNSRC-1:0] rr_ptr_r;
  logic [CW-1:0]      word_cnt_r;
  logic [LOGNSRC-1:0] pick_s;
  logic               any_req_s;
  logic               beat_s;
  logic               last_word_s;

  // First requesting source at or above rr_ptr, wrapping; the lowest offset wins.
  always_comb begin
    logic [LOGNSRC-1:0] cand;
    pick_s    = rr_ptr_r;
    any_req_s = |src_valid;
    for (int i = NSRC - 1; i >= 0; i--) begin
      cand   = rr_ptr_r + LOGNSRC'(i);
      pick_s = src_valid[cand] ? cand : pick_s;
    end
  end

  // Datapath mux and ready steering toward the locked source only.
  always_comb begin
    src_ready = {NSRC{1'b0}};
    wr_data   = src_data[grant_id*DWIDTH +: DWIDTH];
    if (state_r == LOCKED) begin
      wr_valid            = src_valid[grant_id];
      src_ready[grant_id] = wr_ready;
    end else begin
      wr_valid = 1'b0;
    end
  end

  assign busy        = (state_r == LOCKED);
  assign beat_s      = wr_valid & wr_ready;
  assign last_word_s = (word_cnt_r == CW'(NWORDS - 1));

  // Grant FSM: lock on a request in IDLE, release after the last beat of the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rr_ptr_r   <= {LOGNSRC{1'b0}};
      word_cnt_r <= {CW{1'b0}};
      grant_id   <= {LOGNSRC{1'b0}};
      block_done <= 1'b0;
    end else begin
      block_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_id   <= pick_s;
            word_cnt_r <= {CW{1'b0}};
            state_r    <= LOCKED;
          end
        end
        LOCKED: begin
          if (beat_s) begin
            if (last_word_s) begin
              state_r    <= IDLE;
              block_done <= 1'b1;
              rr_ptr_r   <= grant_id + LOGNSRC'(1);
              word_cnt_r <= {CW{1'b0}};
            end else begin
              word_cnt_r <= word_cnt_r + CW'(1);
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          word_cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_write_arbiter.sv
// Directed bench for block_write_arbiter: single source, contention, rotation,
// backpressure, source stall and mid-block reset.
module tb_block_write_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   src_valid;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic         wr_valid;
  logic [31:0]  wr_data;
  logic         wr_ready;
  logic         busy;
  logic [1:0]   grant_id;
  logic         block_done;

  int vectors = 0;
  int miscompares = 0;
  int word_ctr[4];
  int beats;
  int dones;
  int locked;

  logic [3:0]  s_ready;
  logic        s_wv, s_busy, s_done;
  logic [31:0] s_data;
  logic [1:0]  s_gid;

  always #5 clk = ~clk;

  block_write_arbiter #(.LOGNSRC(2), .DWIDTH(32), .NWORDS(11)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .grant_id(grant_id), .block_done(block_done)
  );

  function automatic logic [31:0] wexp(input int src, input int w);
    logic [7:0]  s8;
    logic [23:0] w24;
    s8  = src[7:0];
    w24 = w[23:0];
    return {s8, w24};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < 4; i++) src_data[i*32 +: 32] = wexp(i, word_ctr[i]);
  endtask

  // One clock: sample outputs on the falling edge, advance the source models after the rising edge.
  task automatic tick();
    logic [3:0] take;
    @(negedge clk);
    s_ready = src_ready; s_wv = wr_valid; s_busy = busy;
    s_done = block_done; s_data = wr_data; s_gid = grant_id;
    take = src_ready & src_valid;
    if (wr_valid && wr_ready) beats++;
    if (block_done) dones++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (take[i]) word_ctr[i]++;
    drive_data();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; src_valid = 4'b0000; wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) word_ctr[i] = 0;
    drive_data();
    tick();
    tick();
    rst_n = 1'b1;
    beats = 0; dones = 0;
  endtask

  initial begin
    // Single source
    do_reset();
    check_vec("rst_busy", s_busy, 1'b0);
    check_vec("rst_ready", s_ready, 4'b0000);
    check_vec("rst_wvalid", s_wv, 1'b0);
    check_vec("rst_gid", s_gid, 2'd0);
    check_vec("rst_done", s_done, 1'b0);
    src_valid = 4'b0010; wr_ready = 1'b1;
    tick();
    check_vec("t1_idle_busy", s_busy, 1'b0);
    check_vec("t1_idle_ready", s_ready, 4'b0000);
    for (int c = 1; c <= 11; c++) begin
      tick();
      check_vec("t1_ready", s_ready, 4'b0010);
      check_vec("t1_gid", s_gid, 2'd1);
      check_vec("t1_data", s_data, wexp(1, c - 1));
    end
    tick();
    check_vec("t1_done", s_done, 1'b1);
    check_vec("t1_busy_end", s_busy, 1'b0);
    check_vec("t1_beats", beats, 32'd11);
    check_vec("t1_gid_end", s_gid, 2'd1);

    // Sources 0 and 2 together
    do_reset();
    src_valid = 4'b0101; wr_ready = 1'b1;
    tick();
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < 11; w++) begin
        tick();
        check_vec("t2_data", s_data, wexp(2 * b, w));
        check_vec("t2_ready", s_ready, (b == 0) ? 4'b0001 : 4'b0100);
      end
      tick();
      check_vec("t2_done", s_done, 1'b1);
    end
    tick();
    check_vec("t2_wrap_gid", s_gid, 2'd0);
    check_vec("t2_wrap_busy", s_busy, 1'b1);

    // Rotation over all four sources
    do_reset();
    src_valid = 4'b1111; wr_ready = 1'b1;
    tick();
    for (int b = 0; b < 5; b++) begin
      for (int w = 0; w < 11; w++) begin
        tick();
        if (w == 0) check_vec("t3_gid", s_gid, b % 4);
      end
      tick();
      check_vec("t3_done", s_done, 1'b1);
    end
    check_vec("t3_ndone", dones, 32'd5);

    // Backpressure on source 3
    do_reset();
    src_valid = 4'b1000; wr_ready = 1'b0;
    tick();
    locked = 0;
    for (int c = 1; c <= 23; c++) begin
      wr_ready = (c % 2 == 0);
      tick();
      if (s_busy) locked++;
      if (c <= 22) begin
        check_vec("t4_ready", s_ready, {wr_ready, 3'b000});
        if (c % 2 == 0) check_vec("t4_data", s_data, wexp(3, c / 2 - 1));
      end else begin
        check_vec("t4_done", s_done, 1'b1);
      end
    end
    check_vec("t4_beats", beats, 32'd11);
    check_vec("t4_locked", locked, 32'd22);

    // Granted source stalls mid-block
    do_reset();
    src_valid = 4'b0011; wr_ready = 1'b1;
    tick();
    for (int c = 1; c <= 6; c++) begin
      tick();
      check_vec("t5_pre", s_data, wexp(0, c - 1));
    end
    src_valid = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_vec("t5_busy", s_busy, 1'b1);
      check_vec("t5_gid", s_gid, 2'd0);
      check_vec("t5_ready", s_ready, 4'b0001);
    end
    check_vec("t5_stall_beats", beats, 32'd6);
    src_valid = 4'b0011;
    for (int w = 6; w < 11; w++) begin
      tick();
      check_vec("t5_resume", s_data, wexp(0, w));
    end
    tick();
    check_vec("t5_done", s_done, 1'b1);
    tick();
    check_vec("t5_next_gid", s_gid, 2'd1);
    check_vec("t5_next_data", s_data, wexp(1, 0));

    // Reset in the middle of a block
    do_reset();
    src_valid = 4'b0100; wr_ready = 1'b1;
    tick();
    for (int w = 0; w < 11; w++) tick();
    tick();
    check_vec("t6_done1", s_done, 1'b1);
    for (int w = 0; w < 5; w++) begin
      tick();
      check_vec("t6_blk2", s_data, wexp(2, 11 + w));
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    src_valid = 4'b1110;
    tick();
    check_vec("t6_busy", s_busy, 1'b0);
    check_vec("t6_ready", s_ready, 4'b0000);
    check_vec("t6_wvalid", s_wv, 1'b0);
    check_vec("t6_gid", s_gid, 2'd0);
    beats = 0;
    for (int w = 0; w < 11; w++) begin
      tick();
      check_vec("t6_data", s_data, wexp(1, w));
      check_vec("t6_rdy", s_ready, 4'b0010);
    end
    tick();
    check_vec("t6_done2", s_done, 1'b1);
    check_vec("t6_beats", beats, 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
